// File: rtl/key_event_pkg.sv
// Shared types and default timing constants for the key event decoder.
package key_event_pkg;

  localparam int unsigned CNT_W          = 32;
  localparam int unsigned LONG_CNT_DEF   = 50_000_000;
  localparam int unsigned DBL_CNT_DEF    = 15_000_000;
  localparam int unsigned REPEAT_CNT_DEF = 10_000_000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } key_state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/key_event_decoder.sv
// Classifies debounced key strobes into click / double-click / long-press pulses.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
  parameter int unsigned DBL_CNT    = DBL_CNT_DEF,
  parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_flag,
  input  logic key_value,
  output logic click_pulse,
  output logic dbl_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CNT - 1);

  if (LONG_CNT < 2 || DBL_CNT < 2 || REPEAT_CNT < 2) begin : g_param_check
    $error("key_event_decoder: LONG_CNT, DBL_CNT and REPEAT_CNT must be >= 2");
  end

  key_state_e       r_state;
  key_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_click;
  logic             r_dbl;
  logic             r_long;
  logic             w_click_nxt;
  logic             w_dbl_nxt;
  logic             w_long_nxt;
  logic             w_press;
  logic             w_release;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CNT - 1);
  logic r_repeat;
  logic w_repeat_nxt;
`endif

  assign w_press   = key_flag & ~key_value;
  assign w_release = key_flag &  key_value;

  // State, shared counter and registered pulse outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_click  <= 1'b0;
      r_dbl    <= 1'b0;
      r_long   <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_repeat <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_click  <= w_click_nxt;
      r_dbl    <= w_dbl_nxt;
      r_long   <= w_long_nxt;
`ifdef KEY_REPEAT_EN
      r_repeat <= w_repeat_nxt;
`endif
    end
  end

  // Next-state, next-counter and next-pulse decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_click_nxt  = 1'b0;
    w_dbl_nxt    = 1'b0;
    w_long_nxt   = 1'b0;
`ifdef KEY_REPEAT_EN
    w_repeat_nxt = 1'b0;
`endif

    unique case (r_state)
      IDLE: begin
        if (w_press) begin
          w_state_nxt = PRESS1;
          w_cnt_nxt   = '0;
        end
      end

      PRESS1: begin
        // Long threshold beats a simultaneous release; that release ends the hold.
        if (r_cnt == LONG_LAST) begin
          w_long_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_release ? IDLE : HOLD;
        end else if (w_release) begin
          w_state_nxt = WAIT2;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = sat_inc(r_cnt);
        end
      end

      WAIT2: begin
        // A press on the final gap cycle still forms a double click.
        if (w_press) begin
          w_state_nxt = PRESS2;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DBL_LAST) begin
          w_click_nxt = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = sat_inc(r_cnt);
        end
      end

      PRESS2: begin
        if (w_release) begin
          w_dbl_nxt   = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = sat_inc(r_cnt);
        end
      end

      HOLD: begin
`ifdef KEY_REPEAT_EN
        if (r_cnt == REP_LAST) begin
          w_repeat_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt    = sat_inc(r_cnt);
        end
`endif
        if (w_release) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign click_pulse = r_click;
  assign dbl_pulse   = r_dbl;
  assign long_pulse  = r_long;
`ifdef KEY_REPEAT_EN
  assign repeat_pulse = r_repeat;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: scenario table, reset sequences, random vs. timestamp model.
module tb_key_event_decoder;

  localparam int LONG = 100;
  localparam int DBL  = 30;
  localparam int REP  = 20;
  localparam int WIN  = 320;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_flag = 1'b0;
  logic key_value = 1'b1;
  logic click_pulse, dbl_pulse, long_pulse, repeat_pulse;

  key_event_decoder #(
    .LONG_CNT  (LONG),
    .DBL_CNT   (DBL),
    .REPEAT_CNT(REP)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_flag    (key_flag),
    .key_value   (key_value),
    .click_pulse (click_pulse),
    .dbl_pulse   (dbl_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Timestamp model: mode 0 idle, 1 first press, 2 release gap, 3 second press, 4 held long.
  longint m_t = 0;
  longint m_t0 = 0;
  int     m_mode = 0;
  bit     e_c, e_d, e_l, e_r;

  task automatic model_step(input bit f, input bit v, input bit r);
    bit press, rel;
    e_c = 0; e_d = 0; e_l = 0; e_r = 0;
    press = f && !v;
    rel   = f && v;
    if (r) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (press) begin m_mode = 1; m_t0 = m_t; end
        1: begin
          if (m_t - m_t0 == LONG) begin
            e_l = 1; m_mode = rel ? 0 : 4; m_t0 = m_t;
          end else if (rel) begin
            m_mode = 2; m_t0 = m_t;
          end
        end
        2: begin
          if (press) m_mode = 3;
          else if (m_t - m_t0 == DBL) begin e_c = 1; m_mode = 0; end
        end
        3: if (rel) begin e_d = 1; m_mode = 0; end
        default: begin
`ifdef KEY_REPEAT_EN
          if (((m_t - m_t0) % REP) == 0) e_r = 1;
`endif
          if (rel) m_mode = 0;
        end
      endcase
    end
    m_t++;
  endtask

  // One clock: drive inputs, let the edge happen, compare all pulses with the model.
  task automatic cyc(input bit f, input bit v, input bit r);
    key_flag = f; key_value = v; sys_rst = r;
    @(posedge sys_clk);
    model_step(f, v, r);
    @(negedge sys_clk);
    checks++;
    if ({click_pulse, dbl_pulse, long_pulse, repeat_pulse} !== {e_c, e_d, e_l, e_r}) begin
      errors++;
      $display("FAIL model_pulses cycle=%0d got cdlr=%b%b%b%b exp cdlr=%b%b%b%b", m_t,
               click_pulse, dbl_pulse, long_pulse, repeat_pulse, e_c, e_d, e_l, e_r);
    end
  endtask

  typedef struct {
    int ev_t[4];
    int ev_v[4];
    int rs;
    int re;
    int c;
    int d;
    int l;
  } scen_t;

  function automatic scen_t mk(input int t0, v0, t1, v1, t2, v2, t3, v3, c, d, l);
    scen_t s;
    s.ev_t[0] = t0; s.ev_v[0] = v0;
    s.ev_t[1] = t1; s.ev_v[1] = v1;
    s.ev_t[2] = t2; s.ev_v[2] = v2;
    s.ev_t[3] = t3; s.ev_v[3] = v3;
    s.rs = -1; s.re = -1;
    s.c = c; s.d = d; s.l = l;
    return s;
  endfunction

  task automatic check_kind(input string name, input int idx, input int n, input int first,
                            input int exp_t);
    checks++;
    if (exp_t < 0) begin
      if (n != 0) begin
        errors++;
        $display("FAIL scen%0d_%s got count=%0d first=%0d exp none", idx, name, n, first);
      end
    end else if (n != 1 || first != exp_t) begin
      errors++;
      $display("FAIL scen%0d_%s got count=%0d first=%0d exp one at %0d", idx, name, n, first, exp_t);
    end
  endtask

  // Reset, then play a scenario and check the exact cycle of each pulse kind.
  task automatic run_scen(input int idx, input scen_t s);
    int nc, nd, nl, fc, fd, fl;
    bit f, v, r;
    nc = 0; nd = 0; nl = 0; fc = -1; fd = -1; fl = -1;
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    for (int t = 0; t < WIN; t++) begin
      f = 0; v = 1;
      for (int k = 0; k < 4; k++)
        if (s.ev_t[k] == t) begin f = 1; v = s.ev_v[k][0]; end
      r = (t >= s.rs) && (t <= s.re);
      cyc(f, v, r);
      if (click_pulse) begin nc++; if (fc < 0) fc = t + 1; end
      if (dbl_pulse)   begin nd++; if (fd < 0) fd = t + 1; end
      if (long_pulse)  begin nl++; if (fl < 0) fl = t + 1; end
    end
    check_kind("click", idx, nc, fc, s.c);
    check_kind("dbl",   idx, nd, fd, s.d);
    check_kind("long",  idx, nl, fl, s.l);
  endtask

  scen_t tbl[13];
  scen_t hs;

  initial begin
    // Press = value 0, release = value 1, -1 = unused slot / no pulse expected.
    tbl[0]  = mk(0, 0, 10, 1,  -1, 0,  -1, 0,   41,  -1,  -1);
    tbl[1]  = mk(0, 0, 10, 1,  25, 0,  40, 1,   -1,  41,  -1);
    tbl[2]  = mk(0, 0, 300, 1, -1, 0,  -1, 0,   -1,  -1, 101);
    tbl[3]  = mk(0, 0, 100, 1, 150, 0, 160, 1, 191,  -1, 101);
    tbl[4]  = mk(0, 0, 99, 1,  -1, 0,  -1, 0,  130,  -1,  -1);
    tbl[5]  = mk(0, 0, 10, 1,  40, 0,  50, 1,   -1,  51,  -1);
    tbl[6]  = mk(0, 0, 10, 1,  41, 0, 200, 1,   41,  -1, 142);
    tbl[7]  = mk(0, 0, 5, 0,   10, 1,  -1, 0,   41,  -1,  -1);
    tbl[8]  = mk(0, 0, 10, 1,  20, 1,  -1, 0,   41,  -1,  -1);
    tbl[9]  = mk(3, 1, -1, 0,  -1, 0,  -1, 0,   -1,  -1,  -1);
    tbl[10] = mk(0, 0, 10, 1,  20, 0, 250, 1,   -1, 251,  -1);
    tbl[11] = mk(0, 0, 150, 0, 200, 1, -1, 0,   -1,  -1, 101);
    tbl[12] = mk(0, 0, 10, 1,  39, 0,  45, 1,   -1,  46,  -1);

    @(negedge sys_clk);
    checks++;
    if ({click_pulse, dbl_pulse, long_pulse, repeat_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b%b%b%b exp 0000",
               click_pulse, dbl_pulse, long_pulse, repeat_pulse);
    end

    for (int i = 0; i < 13; i++) run_scen(i, tbl[i]);

    // Reset during the release gap drops the pending click; a fresh press still works.
    hs = mk(0, 0, 10, 1, 100, 0, 110, 1, 141, -1, -1);
    hs.rs = 20; hs.re = 22;
    run_scen(13, hs);

    // Reset during a second press drops the double click; the late release is ignored.
    hs = mk(0, 0, 10, 1, 20, 0, 40, 1, -1, -1, -1);
    hs.rs = 30; hs.re = 31;
    run_scen(14, hs);

    // Random strobes at varying densities, checked every cycle against the model.
    cyc(0, 1, 1);
    for (int seg = 0; seg < 15; seg++) begin
      int rate;
      rate = int'($urandom_range(4, 60));
      for (int i = 0; i < 1000; i++) begin
        bit f, v, r;
        f = ($urandom_range(0, rate) == 0);
        v = 1'($urandom_range(0, 1));
        r = ($urandom_range(0, 2999) == 0);
        cyc(f, v, r);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
